// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver feeding a one-byte holding register with rts flow control,
// framing and overrun error pulses. Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse.
module uart_rx_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       d_rdy,
  output logic       rts,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] D_END = DW'(DIV - 1);
  localparam logic [TW-1:0] T_LO  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HI  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic          sync1_q, rxs_q, rxs_prev_q;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    smp_q, smp_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic [7:0]    dout_q, dout_d;
  logic          d_rdy_q, d_rdy_d;
  logic          rts_q;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          tick, fall, vote, stop_smp, commit, take;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          parity_err_q, parity_err_d;
`endif

  assign tick     = div_q == D_END;
  assign fall     = rxs_prev_q & ~rxs_q;
  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
  assign stop_smp = (state_q == STOP) & ~brk_q & tick & (tick_cnt_q == T_MID);
  assign commit   = stop_smp & rxs_q;
  assign take     = commit & (~d_rdy_q | rd);

  assign dout_d      = take ? shift_q : dout_q;
  assign d_rdy_d     = take | (d_rdy_q & ~rd);
  assign overrun_d   = commit & d_rdy_q & ~rd;
  assign frame_err_d = stop_smp & ~rxs_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_d = stop_smp & (^shift_q ^ par_q);
`endif

  assign dout      = dout_q;
  assign d_rdy     = d_rdy_q;
  assign rts       = rts_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  // Two-stage synchroniser for rx plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Next-state logic: tick_cnt is a bit-phase counter started at the start edge, so tick 0 is each bit's leading edge
  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    brk_d      = brk_q;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    if (tick && state_q != IDLE) begin
      tick_cnt_d = tick_cnt_q == T_END ? '0 : tick_cnt_q + 1'b1;
      smp_d[0]   = tick_cnt_q == T_LO ? rxs_q : smp_q[0];
      smp_d[1]   = tick_cnt_q == T_MID ? rxs_q : smp_q[1];
    end
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          div_d      = '0;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick && tick_cnt_q == T_LO && rxs_q) begin
          state_d = IDLE;
        end else if (tick && tick_cnt_q == T_END) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick && tick_cnt_q == T_HI) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          state_d   = bit_cnt_q == 3'd7 ? PARITY : DATA;
`else
          state_d   = bit_cnt_q == 3'd7 ? STOP : DATA;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && tick_cnt_q == T_HI) begin
          par_d   = vote;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (brk_q) begin
          state_d = rxs_q ? IDLE : STOP;
          brk_d   = ~rxs_q;
        end else if (stop_smp) begin
          state_d = rxs_q ? IDLE : STOP;
          brk_d   = ~rxs_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state, tick divider and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      brk_q      <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Holding register, flow control and one-cycle error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      d_rdy_q      <= 1'b0;
      rts_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      dout_q       <= dout_d;
      d_rdy_q      <= d_rdy_d;
      rts_q        <= d_rdy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with a byte scoreboard and error-pulse counters.
module tb_uart_rx_core;

  localparam int BIT = 32;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // negedge (counted from the start-bit negedge) just before the stop-sample clock edge
  localparam int RD_AT = BIT * STOP_IDX + 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] dout;
  logic       d_rdy, rts, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         pe_cnt = 0;
`endif

  int         n_chk = 0, n_fail = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_dout = 8'h00;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd(rd),
    .dout(dout),
    .d_rdy(d_rdy),
    .rts(rts),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^d ^ par_flip);
`endif
    bit_out(stop_b);
    rx = 1'b1;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!d_rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, d_rdy, 1);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Monitor: every newly presented byte is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!rst) begin
      if (d_rdy && (!prev_rdy || dout != prev_dout)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious byte: got 0x%0h, expected none", dout);
        end else begin
          chk("rx byte", dout, exp_q.pop_front());
        end
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
    end
    prev_rdy  = d_rdy;
    prev_dout = dout;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset dout", dout, 0);
    chk("reset d_rdy", d_rdy, 0);
    chk("reset rts", rts, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    wait_rdy("t1 d_rdy");
    chk("t1 rts", rts, 1);
    chk("t1 dout", dout, 8'hA5);
    repeat (5) @(negedge clk);
    pulse_rd();
    chk("t1 d_rdy after rd", d_rdy, 0);
    chk("t1 rts after rd", rts, 0);
    chk("t1 frame_err count", fe_cnt, 0);
    chk("t1 overrun count", ov_cnt, 0);

    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("t2 d_rdy", d_rdy, 0);
    chk("t2 frame_err count", fe_cnt, 0);

    send(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    chk("t3 frame_err count", fe_cnt, 1);
    chk("t3 d_rdy", d_rdy, 0);
    chk("t3 dout kept", dout, 8'hA5);

    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    chk("t4 dout", dout, 8'h11);
    chk("t4 d_rdy", d_rdy, 1);
    chk("t4 rts", rts, 1);
    chk("t4 overrun count", ov_cnt, 1);

    exp_q.push_back(8'h22);
    fork
      send(8'h22, 1'b1);
      begin
        repeat (RD_AT) @(negedge clk);
        pulse_rd();
      end
    join
    repeat (10) @(negedge clk);
    chk("t5 dout", dout, 8'h22);
    chk("t5 d_rdy", d_rdy, 1);
    chk("t5 overrun count", ov_cnt, 1);
    pulse_rd();
    chk("t5 d_rdy after rd", d_rdy, 0);

    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'(8'h5A >> i));
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst dout", dout, 0);
    chk("t6 rst d_rdy", d_rdy, 0);
    chk("t6 rst rts", rts, 0);
    chk("t6 rst frame_err", frame_err, 0);
    chk("t6 rst overrun", overrun, 0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    exp_q.push_back(8'h0F);
    send(8'h0F, 1'b1);
    wait_rdy("t6 d_rdy");
    chk("t6 dout", dout, 8'h0F);
    pulse_rd();

`ifdef UART_RX_PARITY_EN
    repeat (10) @(negedge clk);
    chk("parity_err before bad frame", pe_cnt, 0);
    par_flip = 1'b1;
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1);
    par_flip = 1'b0;
    wait_rdy("par d_rdy");
    chk("par dout", dout, 8'h07);
    chk("parity_err count", pe_cnt, 1);
    pulse_rd();
`endif

    repeat (20) @(negedge clk);
    chk("scoreboard empty", exp_q.size(), 0);
    chk("total frame_err", fe_cnt, 1);
    chk("total overrun", ov_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
